// File: rtl/beep_pattern_gen.sv
// beep_pattern_gen
// ----------------
// Plays a burst of beeps timed by an external tick (the timer's full_r
// pulse). A trigger latches the beep count and the on/off lengths in
// ticks. While a beep is on, the buzzer pin carries a square tone with a
// half-period of TONE_HALF clk cycles. A stop request aborts the burst at
// once.
//
// Ports:
//   clk        in   system clock, rising edge
//   rst        in   asynchronous reset, active low
//   tick       in   one-cycle time-base pulse
//   trig       in   start-burst request, ignored while busy
//   stop       in   abort request, highest priority
//   beep_num   in   beeps per burst (0: trig ignored)
//   on_ticks   in   ticks per beep-on phase (0 acts as 1)
//   off_ticks  in   ticks per gap phase (0 acts as 1)
//   beep       out  buzzer drive, registered square wave
//   busy       out  high while a burst is playing
//   done       out  one-cycle pulse on normal burst completion
//   beeps_left out  remaining beeps, including the current one
module beep_pattern_gen #(
  parameter int unsigned TONE_HALF = 12500
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic       trig,
  input  logic       stop,
  input  logic [3:0] beep_num,
  input  logic [7:0] on_ticks,
  input  logic [7:0] off_ticks,
  output logic       beep,
  output logic       busy,
  output logic       done,
  output logic [3:0] beeps_left
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ON   = 2'd1,
    S_OFF  = 2'd2
  } state_t;

  localparam logic [15:0] TONE_LAST = 16'(TONE_HALF - 1);

  state_t      state_q, state_d;
  logic [15:0] tone_cnt_q, tone_cnt_d;
  logic [7:0]  tick_cnt_q, tick_cnt_d;
  logic [7:0]  on_len_q, on_len_d;
  logic [7:0]  off_len_q, off_len_d;
  logic [3:0]  beeps_left_q, beeps_left_d;
  logic        beep_q, beep_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;

  // Next-state and next-output computation for the burst sequencer.
  always_comb begin
    state_d      = state_q;
    tone_cnt_d   = tone_cnt_q;
    tick_cnt_d   = tick_cnt_q;
    on_len_d     = on_len_q;
    off_len_d    = off_len_q;
    beeps_left_d = beeps_left_q;
    beep_d       = beep_q;
    busy_d       = busy_q;
    done_d       = 1'b0;

    if (stop) begin
      // Abort wins over tick and trig in the same cycle; no done pulse.
      state_d      = S_IDLE;
      tone_cnt_d   = 16'd0;
      tick_cnt_d   = 8'd0;
      beeps_left_d = 4'd0;
      beep_d       = 1'b0;
      busy_d       = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (trig && (beep_num != 4'd0)) begin
            // Zero lengths are stored as 1 so the terminal compare
            // (length-1) never underflows.
            on_len_d     = (on_ticks  == 8'd0) ? 8'd1 : on_ticks;
            off_len_d    = (off_ticks == 8'd0) ? 8'd1 : off_ticks;
            beeps_left_d = beep_num;
            tick_cnt_d   = 8'd0;
            tone_cnt_d   = 16'd0;
            beep_d       = 1'b1;
            busy_d       = 1'b1;
            state_d      = S_ON;
          end else begin
            state_d = S_IDLE;
          end
        end

        S_ON: begin
          if (tone_cnt_q == TONE_LAST) begin
            tone_cnt_d = 16'd0;
            beep_d     = ~beep_q;
          end else begin
            tone_cnt_d = tone_cnt_q + 16'd1;
          end

          if (tick) begin
            if (tick_cnt_q == (on_len_q - 8'd1)) begin
              tick_cnt_d   = 8'd0;
              tone_cnt_d   = 16'd0;
              beep_d       = 1'b0;
              beeps_left_d = beeps_left_q - 4'd1;
              if (beeps_left_q == 4'd1) begin
                // Last beep finished: the trailing gap is not played.
                state_d = S_IDLE;
                busy_d  = 1'b0;
                done_d  = 1'b1;
              end else begin
                state_d = S_OFF;
              end
            end else begin
              tick_cnt_d = tick_cnt_q + 8'd1;
            end
          end else begin
            tick_cnt_d = tick_cnt_q;
          end
        end

        S_OFF: begin
          beep_d     = 1'b0;
          tone_cnt_d = 16'd0;
          if (tick) begin
            if (tick_cnt_q == (off_len_q - 8'd1)) begin
              // Next beep starts with a fresh tone phase, pin high.
              tick_cnt_d = 8'd0;
              beep_d     = 1'b1;
              state_d    = S_ON;
            end else begin
              tick_cnt_d = tick_cnt_q + 8'd1;
            end
          end else begin
            tick_cnt_d = tick_cnt_q;
          end
        end

        default: begin
          state_d      = S_IDLE;
          tone_cnt_d   = 16'd0;
          tick_cnt_d   = 8'd0;
          beeps_left_d = 4'd0;
          beep_d       = 1'b0;
          busy_d       = 1'b0;
        end
      endcase
    end
  end

  // State and output registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      tone_cnt_q   <= 16'd0;
      tick_cnt_q   <= 8'd0;
      on_len_q     <= 8'd0;
      off_len_q    <= 8'd0;
      beeps_left_q <= 4'd0;
      beep_q       <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      tone_cnt_q   <= tone_cnt_d;
      tick_cnt_q   <= tick_cnt_d;
      on_len_q     <= on_len_d;
      off_len_q    <= off_len_d;
      beeps_left_q <= beeps_left_d;
      beep_q       <= beep_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  assign beep       = beep_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign beeps_left = beeps_left_q;

endmodule

// File: tb/tb_beep_pattern_gen.sv
// Testbench for beep_pattern_gen. A driver issues per-cycle stimulus and
// pushes the expected post-edge outputs, computed by a burst-level model,
// into a queue. A monitor pops and compares after every rising edge.
module tb_beep_pattern_gen;

  localparam int TH = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       tick = 1'b0;
  logic       trig = 1'b0;
  logic       stop = 1'b0;
  logic [3:0] beep_num = 4'd0;
  logic [7:0] on_ticks = 8'd0;
  logic [7:0] off_ticks = 8'd0;
  logic       beep;
  logic       busy;
  logic       done;
  logic [3:0] beeps_left;

  beep_pattern_gen #(.TONE_HALF(TH)) dut (
    .clk        (clk),
    .rst        (rst),
    .tick       (tick),
    .trig       (trig),
    .stop       (stop),
    .beep_num   (beep_num),
    .on_ticks   (on_ticks),
    .off_ticks  (off_ticks),
    .beep       (beep),
    .busy       (busy),
    .done       (done),
    .beeps_left (beeps_left)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int done_seen = 0;
  int gcyc = 0;

  // Expected {beep, busy, done, beeps_left} after the next rising edge.
  logic [6:0] exp_q[$];

  // Burst-level reference model state.
  int m_active = 0;
  int m_n = 0;
  int m_on = 1;
  int m_off = 1;
  int m_t = 0;   // ticks counted since the burst started
  int m_ph = 0;  // cycles since the current on/off phase began

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  task automatic model_reset();
    m_active = 0;
    m_t = 0;
    m_ph = 0;
  endtask

  task automatic model_step(input logic t_trig, input logic t_stop, input logic t_tick,
                            input logic [3:0] num, input logic [7:0] on, input logic [7:0] off);
    int per;
    int total;
    int p;
    int idx;
    logic m_done;
    logic [6:0] e;
    m_done = 1'b0;
    if (t_stop) begin
      m_active = 0;
    end else if (m_active == 0) begin
      if (t_trig && num != 4'd0) begin
        m_active = 1;
        m_n = int'(num);
        m_on = (on == 8'd0) ? 1 : int'(on);
        m_off = (off == 8'd0) ? 1 : int'(off);
        m_t = 0;
        m_ph = 0;
      end
    end else begin
      m_ph++;
      if (t_tick) begin
        m_t++;
        total = m_n * m_on + (m_n - 1) * m_off;
        if (m_t == total) begin
          m_active = 0;
          m_done = 1'b1;
        end else begin
          p = m_t % (m_on + m_off);
          if (p == 0 || p == m_on) m_ph = 0;
        end
      end
    end
    if (m_active != 0) begin
      per = m_on + m_off;
      p = m_t % per;
      idx = m_t / per;
      if (p < m_on)
        e = {(((m_ph / TH) % 2) == 0) ? 1'b1 : 1'b0, 1'b1, 1'b0, 4'(m_n - idx)};
      else
        e = {1'b0, 1'b1, 1'b0, 4'(m_n - idx - 1)};
    end else begin
      e = {1'b0, 1'b0, m_done, 4'd0};
    end
    exp_q.push_back(e);
  endtask

  // One cycle of stimulus, driven on the falling edge.
  task automatic cyc(input logic t_trig, input logic t_stop, input logic t_tick,
                     input logic [3:0] num, input logic [7:0] on, input logic [7:0] off);
    @(negedge clk);
    trig = t_trig;
    stop = t_stop;
    tick = t_tick;
    beep_num = num;
    on_ticks = on;
    off_ticks = off;
    gcyc++;
    model_step(t_trig, t_stop, t_tick, num, on, off);
  endtask

  task automatic run(input int n, input int period, input logic t_trig,
                     input logic [3:0] num, input logic [7:0] on, input logic [7:0] off);
    for (int i = 0; i < n; i++)
      cyc(t_trig, 1'b0, ((gcyc % period) == period - 1), num, on, off);
  endtask

  // Monitor: compare DUT outputs against the queued expectations.
  initial begin
    logic [6:0] e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checks++;
        if ({beep, busy, done, beeps_left} !== e) begin
          errors++;
          $display("FAIL outputs cyc %0d: got beep=%b busy=%b done=%b left=%0d, expected beep=%b busy=%b done=%b left=%0d",
                   gcyc, beep, busy, done, beeps_left, e[6], e[5], e[4], e[3:0]);
        end
        if (done === 1'b1) done_seen++;
      end
    end
  end

  initial begin
    int d0;
    // Reset values.
    repeat (3) @(negedge clk);
    check("reset beep", int'(beep), 0);
    check("reset busy", int'(busy), 0);
    check("reset done", int'(done), 0);
    check("reset beeps_left", int'(beeps_left), 0);
    #2 rst = 1'b1;
    model_reset();
    run(3, 20, 1'b0, 4'd0, 8'd0, 8'd0);

    // Basic burst: N=2, on=3, off=2, tick every 20 cycles.
    d0 = done_seen;
    cyc(1'b1, 1'b0, 1'b0, 4'd2, 8'd3, 8'd2);
    run(200, 20, 1'b0, 4'd2, 8'd3, 8'd2);
    check("basic done count", done_seen - d0, 1);
    check("basic busy after", int'(busy), 0);

    // beep_num=0 ignores trig.
    d0 = done_seen;
    cyc(1'b1, 1'b0, 1'b0, 4'd0, 8'd2, 8'd2);
    run(10, 3, 1'b0, 4'd0, 8'd2, 8'd2);
    check("num0 busy", int'(busy), 0);
    check("num0 done count", done_seen - d0, 0);

    // Zero lengths act as 1 tick, N=3.
    d0 = done_seen;
    cyc(1'b1, 1'b0, 1'b0, 4'd3, 8'd0, 8'd0);
    run(40, 5, 1'b0, 4'd3, 8'd0, 8'd0);
    check("zero-len done count", done_seen - d0, 1);

    // Trig held while busy and beep_num changed to 9 mid-burst.
    d0 = done_seen;
    cyc(1'b1, 1'b0, 1'b0, 4'd2, 8'd2, 8'd2);
    run(30, 7, 1'b1, 4'd9, 8'd5, 8'd5);
    run(40, 7, 1'b0, 4'd9, 8'd5, 8'd5);
    check("busy-trig done count", done_seen - d0, 1);

    // Stop during ON with a coincident tick, then a fresh burst.
    d0 = done_seen;
    cyc(1'b1, 1'b0, 1'b0, 4'd3, 8'd4, 8'd1);
    run(10, 4, 1'b0, 4'd3, 8'd4, 8'd1);
    cyc(1'b0, 1'b1, 1'b1, 4'd3, 8'd4, 8'd1);
    run(3, 4, 1'b0, 4'd3, 8'd4, 8'd1);
    check("stop done count", done_seen - d0, 0);
    cyc(1'b1, 1'b0, 1'b0, 4'd1, 8'd2, 8'd1);
    run(20, 4, 1'b0, 4'd1, 8'd2, 8'd1);

    // Tick coincident with the accepting trig is not counted.
    cyc(1'b1, 1'b0, 1'b1, 4'd1, 8'd2, 8'd1);
    run(20, 6, 1'b0, 4'd1, 8'd2, 8'd1);

    // Async reset asserted mid-OFF, between clock edges.
    cyc(1'b1, 1'b0, 1'b0, 4'd2, 8'd1, 8'd5);
    run(12, 5, 1'b0, 4'd2, 8'd1, 8'd5);
    check("pre-reset busy", int'(busy), 1);
    check("pre-reset beep", int'(beep), 0);
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    check("async reset busy", int'(busy), 0);
    check("async reset beeps_left", int'(beeps_left), 0);
    check("async reset beep", int'(beep), 0);
    model_reset();
    @(negedge clk);
    #2 rst = 1'b1;
    run(15, 3, 1'b0, 4'd2, 8'd1, 8'd5);
    check("post-reset idle", int'(busy), 0);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++)
      cyc(($urandom_range(19) == 0), ($urandom_range(99) == 0), ($urandom_range(3) == 0),
          4'($urandom_range(4)), 8'($urandom_range(3)), 8'($urandom_range(3)));
    run(60, 2, 1'b0, 4'd0, 8'd0, 8'd0);

    // Drain the scoreboard with a bounded wait.
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
    if (exp_q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/beep_pattern_gen.md
# beep_pattern_gen

Downstream consumer of the programmable timer's one-cycle `full_r` notification. Each notification is treated as a time-base tick. On a trigger, the block plays a burst of N beeps with programmable on/off lengths in ticks. While a beep is on, it drives the buzzer pin with a fixed-frequency square tone.

## Interface
- `TONE_HALF`, default 12500: half-period of the buzzer tone in clk cycles (2 kHz at 50 MHz); legal range 2..65535.
- `clk`  in  1  system clock; all logic is on the rising edge.
- `rst`  in  1  reset, asynchronous, active-low.
- `tick`  in  1  time-base pulse, one cycle wide; driven by the timer's `full_r`.
- `trig`  in  1  start-burst request, level sampled each cycle.
- `stop`  in  1  abort request, level sampled each cycle.
- `beep_num`  in  4  beeps per burst; 0 means trig is ignored.
- `on_ticks`  in  8  ticks per beep-on phase; 0 is treated as 1.
- `off_ticks`  in  8  ticks per gap phase; 0 is treated as 1.
- `beep`  out  1  buzzer drive (registered square wave).
- `busy`  out  1  high in ON or OFF state.
- `done`  out  1  one-cycle pulse when a burst completes normally.
- `beeps_left`  out  4  remaining beeps, including the current one.

## Operation
- States: IDLE, ON, OFF. Reset puts the block in IDLE with `beep`=0, `busy`=0, `done`=0, `beeps_left`=0, and all counters at 0.
- Leaving IDLE:
  - Condition: `trig`=1 and `beep_num`!=0.
  - Latches `beep_num`, `on_ticks` and `off_ticks`.
  - Sets `beeps_left`=`beep_num` and the tick counter to 0, then enters ON.
  - Input changes during a burst have no effect.
- `trig` while busy is ignored. A trig can start a new burst only once the block is back in IDLE.
- ON state:
  - The tone counter counts 0..TONE_HALF-1. `beep` toggles on each wrap.
  - On ON entry, `beep`=1 and the tone counter is 0.
  - Each `tick` increments the tick counter.
  - On a `tick` with tick counter = latched on-length-1:
    - The tick counter clears and `beeps_left` decrements.
    - If `beeps_left` was 1: go to IDLE and pulse `done`.
    - Otherwise: go to OFF.
- OFF state:
  - `beep`=0 and the tone counter is held at 0.
  - On a `tick` with tick counter = latched off-length-1, the tick counter clears and the block enters ON.
- `stop`=1 in any state:
  - Next state is IDLE, with `beep`=0, `beeps_left`=0 and `busy`=0.
  - No `done` pulse.
  - `stop` has priority over `tick` and `trig` in the same cycle.
- Widths:
  - Tone counter is 16 bits.
  - Tick counter is 8 bits and never exceeds the latched length-1, so it does not wrap.
  - `beeps_left` is 4 bits.

## Timing
- `trig` sampled high in cycle n: from n+1, `busy`=1, `beep`=1, `beeps_left`=`beep_num`.
- A `tick` coincident with the accepting `trig` is not counted.
- Tone: `beep` toggles at cycles n+1+k·TONE_HALF for k≥1, while the block stays in ON.
- Terminal tick in ON at cycle m:
  - `beep`=0 from m+1.
  - From m+1 the state is OFF or IDLE.
  - When going to IDLE, `done`=1 in cycle m+1 only and `busy`=0 from m+1.
- Terminal tick in OFF at cycle m: ON from m+1 with `beep`=1 and the tone phase restarted.
- Burst length in ticks is N·on + (N-1)·off; the trailing gap is not played.
- All outputs are registered. No combinational path runs from inputs to outputs.
- Asserting `rst` mid-burst forces the reset values immediately.
- After `rst` releases, the block stays in IDLE until a new `trig`.

## Test plan
- Basic burst:
  - Stimulus: TONE_HALF=4, `beep_num`=2, on=3, off=2, `tick` every 20 cycles, `trig` for 1 cycle.
  - Required: exactly 2 on-phases of 3 ticks each, `beep` toggling every 4 cycles, one 2-tick gap, `done` high for exactly one cycle, `busy`=0 afterwards.
- Zero handling:
  - `beep_num`=0 with `trig`: `busy` stays 0 and no `done`.
  - on=0, off=0, N=3: each phase lasts 1 tick and `beeps_left` steps 3→2→1→0.
- Trig while busy, plus parameter change mid-burst (change `beep_num` to 9): the burst still plays the originally latched count and timing; no restart.
- `stop` during ON, with a coincident `tick`: IDLE next cycle, `beep`=0, `beeps_left`=0, no `done`. A subsequent `trig` starts a fresh burst.
- Async reset asserted mid-OFF, between clock edges: outputs go to their reset values immediately. After release the block stays IDLE until `trig`.
- Simultaneous `tick` and accepting `trig`: the tick is not counted, so the on-phase spans a full on_ticks subsequent ticks.
